afifo_wr_arb: RTL and testbench
===============================

AFIFO_WR_ARB -- requirements
Module: afifo_wr_arb

Interface
REQ-001 SHALL provide parameter NREQ, default 4, number of write requesters sharing one afifo write port (2..8).
REQ-002 SHALL provide parameter DATASIZE, default 8, data width matching the afifo DATASIZE.
REQ-003 SHALL provide parameter BURST, default 4, maximum beats per grant before re-arbitration (1..16).
REQ-004 wclk  in  1  write-domain clock; reset wrst_n, asynchronous, active-low; clock wclk.
REQ-005 wrst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NREQ  per-requester data-valid; bit i belongs to requester i.
REQ-007 req_data  in  NREQ*DATASIZE  requester i data in bits [i*DATASIZE +: DATASIZE].
REQ-008 req_ready  out  NREQ  per-requester accept; a beat transfers when req_valid[i] and req_ready[i] are high on a wclk edge.
REQ-009 wfull  in  1  afifo full flag, wclk domain.
REQ-010 winc  out  1  afifo write enable.
REQ-011 wdata  out  DATASIZE  afifo write data.
REQ-012 grant_id  out  clog2(NREQ)  index of the current or last granted requester.
REQ-013 busy  out  1  high while the FSM is in GRANT.

Function
REQ-014 The FSM SHALL have two states, IDLE and GRANT, registered on wclk.
REQ-015 In IDLE with any req_valid high, the block SHALL pick the first valid requester in round-robin order starting at last_gnt+1 (modulo NREQ), load grant_id, clear the beat counter, and enter GRANT on the next edge (one-cycle arbitration latency; no transfer in IDLE).
REQ-016 In IDLE with no req_valid high, the block SHALL remain in IDLE with all req_ready low and winc low.
REQ-017 In GRANT, req_ready[grant_id] SHALL equal !wfull; every other req_ready bit SHALL be 0 (combinational).
REQ-018 In GRANT, winc SHALL equal req_valid[grant_id] & !wfull, and wdata SHALL equal the req_data slice of grant_id (combinational, same cycle).
REQ-019 Each transfer SHALL increment the beat counter; the counter SHALL be wide enough to hold BURST without wrap.
REQ-020 While wfull is high in GRANT, the block SHALL keep the grant, hold the beat counter, and drive winc low.
REQ-021 GRANT SHALL exit to IDLE on the edge where the BURST-th beat transfers, or on any edge where req_valid[grant_id] is low; last_gnt SHALL then take grant_id.
REQ-022 A requester dropping req_valid mid-burst SHALL forfeit its grant; no data is lost because no transfer occurs while valid is low.
REQ-023 Requests raised in GRANT by non-granted requesters SHALL wait until the next IDLE arbitration; no preemption.
REQ-024 With only one requester active continuously, it SHALL receive BURST beats, then one IDLE cycle, then re-grant of itself.
REQ-025 Simultaneous final beat and wfull rise: the final beat counts only if the transfer occurs (wfull low that cycle).

Reset
REQ-026 On wrst_n low, the FSM SHALL enter IDLE immediately; the beat counter SHALL clear; grant_id SHALL be 0; last_gnt SHALL be NREQ-1 so requester 0 has first priority.
REQ-027 During and immediately after reset, winc, busy and all req_ready bits SHALL be 0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst with no further winc pulse; the first post-reset grant follows REQ-026 priority.

Verification
REQ-029 Reset release, req_valid=4'b0101 held -> grant_id=0 after 1 cycle, 4 winc beats of requester 0 data, IDLE cycle, then grant_id=2 for 4 beats.
REQ-030 All four valid continuously, BURST=4 -> grant order 0,1,2,3,0; each grant exactly 4 beats; 20 transfers take 20 cycles of GRANT plus 5 IDLE cycles.
REQ-031 Requester 1 alone, wfull high for 3 cycles after beat 2 -> winc low and req_ready[1] low for those 3 cycles, counter holds at 2, beats 3-4 follow, grant released after beat 4.
REQ-032 Requester 3 granted, drops valid after beat 1 while requester 0 valid -> GRANT exits that edge, next grant is requester 0, requester 3 total = 1 beat.
REQ-033 wrst_n pulsed low during beat 2 of requester 2 -> winc, busy and req_ready drop within the reset cycle; after release, with all valid, first grant_id=0.
REQ-034 Integrated with afifo (ADDRSIZE=4), two requesters streaming distinct data patterns -> read side recovers each requester's sequence in order with no loss or duplication.

Source files
------------

// File: rtl/afifo_wr_arb_if.sv
// afifo_wr_arb_if -- requester / afifo write-side bundle for afifo_wr_arb.
//   req_valid [NREQ]           per-requester data valid
//   req_data  [NREQ*DATASIZE]  requester i data in [i*DATASIZE +: DATASIZE]
//   req_ready [NREQ]           per-requester accept
//   wfull                      afifo full flag (wclk domain)
//   winc / wdata               afifo write enable / data
//   grant_id                   current or last granted requester
//   busy                       arbiter holds a grant
// master: requesters + afifo side; slave: the arbiter.
interface afifo_wr_arb_if #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8
);
    localparam int GW = $clog2(NREQ);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ*DATASIZE-1:0] req_data;
    logic [NREQ-1:0]          req_ready;
    logic                     wfull;
    logic                     winc;
    logic [DATASIZE-1:0]      wdata;
    logic [GW-1:0]            grant_id;
    logic                     busy;

    modport master (
        output req_valid, req_data, wfull,
        input  req_ready, winc, wdata, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data, wfull,
        output req_ready, winc, wdata, grant_id, busy
    );
endinterface

// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb -- round-robin arbiter sharing one afifo write port among
// NREQ requesters. A grant lasts up to BURST beats, or ends when the granted
// requester drops valid. Arbitration takes one IDLE cycle; there is no
// preemption.
//   wclk    write-domain clock
//   wrst_n  asynchronous active-low reset
//   bus     afifo_wr_arb_if.slave (requester handshakes, afifo write port,
//           grant_id, busy)
module afifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int DATASIZE = 8,
    parameter int BURST    = 4
) (
    input  logic           wclk,
    input  logic           wrst_n,
    afifo_wr_arb_if.slave  bus
);
    localparam int GW = $clog2(NREQ);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gnt_q, gnt_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] pick;
    logic          any_valid;
    logic          gnt_valid;
    logic          xfer;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic          found;
        int unsigned   idx;
        logic [GW-1:0] idx_g;
        found = 1'b0;
        pick  = last_q;
        idx   = 0;
        idx_g = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx   = (32'(last_q) + k) % NREQ;
            idx_g = GW'(idx);
            if (!found && bus.req_valid[idx_g]) begin
                pick  = idx_g;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        any_valid = |bus.req_valid;
        gnt_valid = bus.req_valid[gnt_q];
        xfer      = (state_q == GRANT) && gnt_valid && !bus.wfull;
    end

    // State register
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= GW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!gnt_valid) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                end else if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    // Release on the edge that carries the BURST-th beat.
                    if (cnt_q == CW'(BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = gnt_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: decoded from registered state, so reset clears them at once.
    always_comb begin
        bus.req_ready = '0;
        bus.winc      = 1'b0;
        bus.wdata     = '0;
        bus.busy      = 1'b0;
        bus.grant_id  = gnt_q;
        if (state_q == GRANT) begin
            bus.busy             = 1'b1;
            bus.req_ready[gnt_q] = !bus.wfull;
            bus.winc             = gnt_valid && !bus.wfull;
            bus.wdata            = bus.req_data[gnt_q*DATASIZE +: DATASIZE];
        end
    end
endmodule

// File: tb/tb_afifo_wr_arb.sv
// tb_afifo_wr_arb -- directed bench for afifo_wr_arb (NREQ=4, DATASIZE=8,
// BURST=4). Inputs change 1 time unit after the rising edge; outputs are
// sampled 2 time units after it.
module tb_afifo_wr_arb;
    localparam int NREQ     = 4;
    localparam int DATASIZE = 8;
    localparam int BURST    = 4;

    logic wclk;
    logic wrst_n;
    int   n_checks;
    int   n_pass;

    afifo_wr_arb_if #(.NREQ(NREQ), .DATASIZE(DATASIZE)) bus ();

    afifo_wr_arb #(.NREQ(NREQ), .DATASIZE(DATASIZE), .BURST(BURST)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [7:0] pat(input int id, input int b);
        logic [7:0] v;
        v = 8'((id << 4) | (b & 15));
        return v;
    endfunction

    task automatic cyc();
        @(posedge wclk);
        #1;
    endtask

    task automatic exp_idle(input string tag);
        #1;
        chk({tag, ".busy"},  32'(bus.busy), 32'd0);
        chk({tag, ".winc"},  32'(bus.winc), 32'd0);
        chk({tag, ".ready"}, 32'(bus.req_ready), 32'd0);
        cyc();
    endtask

    // Expect n consecutive transferring beats of requester id.
    task automatic exp_grant(input string tag, input int id, input int n);
        for (int b = 0; b < n; b++) begin
            bus.req_data[id*DATASIZE +: DATASIZE] = pat(id, b);
            #1;
            chk({tag, ".busy"},  32'(bus.busy), 32'd1);
            chk({tag, ".gid"},   32'(bus.grant_id), 32'(id));
            chk({tag, ".winc"},  32'(bus.winc), 32'd1);
            chk({tag, ".wdata"}, 32'(bus.wdata), 32'(pat(id, b)));
            chk({tag, ".ready"}, 32'(bus.req_ready), 32'(1 << id));
            cyc();
        end
    endtask

    task automatic do_reset();
        wrst_n        = 1'b0;
        bus.req_valid = '0;
        bus.wfull     = 1'b0;
        cyc();
        cyc();
        wrst_n = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        wrst_n        = 1'b0;
        bus.req_valid = '0;
        bus.wfull     = 1'b0;
        bus.req_data  = '0;
        cyc();

        // Reset state, with requests already pending.
        bus.req_valid = 4'b0101;
        cyc();
        #1;
        chk("rst.busy",  32'(bus.busy), 32'd0);
        chk("rst.winc",  32'(bus.winc), 32'd0);
        chk("rst.ready", 32'(bus.req_ready), 32'd0);
        chk("rst.gid",   32'(bus.grant_id), 32'd0);
        cyc();

        // Two requesters: 0 gets BURST beats, idle, then 2, idle, then 0 again.
        wrst_n = 1'b1;
        exp_idle("a.arb0");
        exp_grant("a.g0", 0, BURST);
        exp_idle("a.arb2");
        exp_grant("a.g2", 2, BURST);
        exp_idle("a.arb0b");
        exp_grant("a.g0b", 0, 1);

        // All requesters: order 0,1,2,3,0, each separated by one idle cycle.
        do_reset();
        bus.req_valid = 4'b1111;
        exp_idle("b.i0");
        exp_grant("b.g0", 0, BURST);
        exp_idle("b.i1");
        exp_grant("b.g1", 1, BURST);
        exp_idle("b.i2");
        exp_grant("b.g2", 2, BURST);
        exp_idle("b.i3");
        exp_grant("b.g3", 3, BURST);
        exp_idle("b.i4");
        exp_grant("b.g0b", 0, BURST);

        // wfull stalls requester 1 for 3 cycles after beat 2; grant and count hold.
        do_reset();
        bus.req_valid = 4'b0010;
        exp_idle("c.arb");
        exp_grant("c.pre", 1, 2);
        bus.wfull = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("c.stall.busy",  32'(bus.busy), 32'd1);
            chk("c.stall.gid",   32'(bus.grant_id), 32'd1);
            chk("c.stall.winc",  32'(bus.winc), 32'd0);
            chk("c.stall.ready", 32'(bus.req_ready), 32'd0);
            cyc();
        end
        bus.wfull = 1'b0;
        exp_grant("c.post", 1, 2);
        exp_idle("c.release");

        // Requester 3 drops valid after one beat; requester 0 waits, then wins.
        do_reset();
        bus.req_valid = 4'b1000;
        exp_idle("d.arb");
        bus.req_valid = 4'b1001;
        exp_grant("d.g3", 3, 1);
        bus.req_valid = 4'b0001;
        #1;
        chk("d.drop.busy",  32'(bus.busy), 32'd1);
        chk("d.drop.gid",   32'(bus.grant_id), 32'd3);
        chk("d.drop.winc",  32'(bus.winc), 32'd0);
        chk("d.drop.ready", 32'(bus.req_ready), 32'b1000);
        cyc();
        exp_idle("d.arb0");
        exp_grant("d.g0", 0, BURST);

        // Reset during beat 2 of requester 2; outputs drop immediately.
        do_reset();
        bus.req_valid = 4'b0100;
        exp_idle("e.arb");
        exp_grant("e.b1", 2, 1);
        #1;
        chk("e.b2.winc", 32'(bus.winc), 32'd1);
        wrst_n = 1'b0;
        #1;
        chk("e.rst.winc",  32'(bus.winc), 32'd0);
        chk("e.rst.busy",  32'(bus.busy), 32'd0);
        chk("e.rst.ready", 32'(bus.req_ready), 32'd0);
        chk("e.rst.gid",   32'(bus.grant_id), 32'd0);
        cyc();
        wrst_n        = 1'b1;
        bus.req_valid = 4'b1111;
        exp_idle("e.arb0");
        exp_grant("e.g0", 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
